// File: rtl/p_layer.sv
// Purpose : PRESENT-style bit-permutation layer (pLayer) between the S-box layer and key addition.
// Latency : exactly 1 cycle from in_valid to out_valid; one word per cycle.
// Backpr. : none; every valid word is accepted, and the output holds its value while idle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears permuted and out_valid
//   in_valid  original carries a word this cycle
//   original  SIZE-bit state word to permute
//   inv       (P_LAYER_INV_EN only) 1 selects the inverse permutation
//   out_valid permuted holds a fresh result
//   permuted  registered permuted state word
//
// Optional feature macro: P_LAYER_INV_EN adds the inv port and the inverse wiring.
// SIZE must be a multiple of 4 and at least 8.
module p_layer #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [SIZE-1:0] original,
`ifdef P_LAYER_INV_EN
  input  logic            inv,
`endif
  output logic            out_valid,
  output logic [SIZE-1:0] permuted
);

  localparam int Q = SIZE / 4;

  logic [SIZE-1:0] w_fwd;
  logic [SIZE-1:0] w_next;
  logic [SIZE-1:0] r_perm;
  logic            r_valid;

  // Written in gather form: output bit o takes input bit i where
  // P(i) = (i mod 4)*Q + i/4 == o, i.e. i = 4*(o mod Q) + o/Q.
  for (genvar go = 0; go < SIZE; go++) begin : g_fwd
    assign w_fwd[go] = original[4*(go % Q) + go / Q];
  end

`ifdef P_LAYER_INV_EN
  logic [SIZE-1:0] w_inv;

  // Inverse sends input bit j to j/Q + 4*(j mod Q); gathered, output bit o
  // takes input bit (o mod 4)*Q + o/4.
  for (genvar go = 0; go < SIZE; go++) begin : g_inv
    assign w_inv[go] = original[(go % 4)*Q + go / 4];
  end

  assign w_next = inv ? w_inv : w_fwd;
`else
  assign w_next = w_fwd;
`endif

  // Capture only on in_valid so an idle (possibly X) input never disturbs the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perm  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_perm <= w_next;
      end
    end
  end

  assign permuted  = r_perm;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_p_layer.sv
module tb_p_layer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] original = '0;
  logic        inv = 1'b0;
  logic        out_valid;
  logic [63:0] permuted;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the outputs must show after the latest edge.
  logic        m_v = 1'b0;
  logic [63:0] m_p = '0;

  p_layer #(.SIZE(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .original (original),
`ifdef P_LAYER_INV_EN
    .inv      (inv),
`endif
    .out_valid(out_valid),
    .permuted (permuted)
  );

  always #5 clk = ~clk;

  // PRESENT destination of input bit i for a 64-bit state.
  function automatic int pos(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction

  function automatic logic [63:0] model_fwd(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y[pos(i)] = x[i];
    return y;
  endfunction

  function automatic logic [63:0] model_inv(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y[i] = x[pos(i)];
    return y;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v = 1'b0;
      m_p = '0;
    end else if (in_valid) begin
      m_v = 1'b1;
      m_p = inv ? model_inv(original) : model_fwd(original);
    end else begin
      m_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cyc_out_valid", {63'd0, out_valid}, {63'd0, m_v});
    chk("cyc_permuted", permuted, m_p);
  end

  task automatic put(input logic v, input logic [63:0] x, input logic iv);
    @(posedge clk);
    #2;
    in_valid = v;
    original = x;
    inv      = iv;
  endtask

  task automatic send_chk(input string nm, input logic [63:0] x, input logic iv,
                          input logic [63:0] exp);
    put(1'b1, x, iv);
    @(posedge clk);
    #1;
    chk(nm, permuted, exp);
    chk({nm, "_vld"}, {63'd0, out_valid}, 64'd1);
  endtask

  logic [63:0] vec_in  [6] = '{64'h0000000000000001, 64'h0000000000000002,
                               64'h0000000000000010, 64'h8000000000000000,
                               64'h000000000000000F, 64'hFFFFFFFFFFFFFFFF};
  logic [63:0] vec_exp [6] = '{64'h0000000000000001, 64'h0000000000010000,
                               64'h0000000000000002, 64'h8000000000000000,
                               64'h0001000100010001, 64'hFFFFFFFFFFFFFFFF};

  initial begin
    logic [63:0] w [5];
    logic [63:0] seen;
    logic [63:0] r;
    logic [63:0] x;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_permuted", permuted, 64'h0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    #1 rst_n = 1'b1;

    // Hand-computed vectors pin both the DUT and the model.
    for (int k = 0; k < 6; k++) begin
      send_chk("vector", vec_in[k], 1'b0, vec_exp[k]);
      chk("model_vector", model_fwd(vec_in[k]), vec_exp[k]);
    end

    // Streaming: five back-to-back words, then idle.
    for (int k = 0; k < 5; k++) begin
      w[k] = {$urandom, $urandom};
      put(1'b1, w[k], 1'b0);
      if (k > 0) chk("stream_order", permuted, model_fwd(w[k-1]));
    end
    put(1'b0, {$urandom, $urandom}, 1'b0);
    chk("stream_last", permuted, model_fwd(w[4]));
    @(posedge clk);
    #1;
    chk("stream_hold", permuted, model_fwd(w[4]));
    chk("stream_idle_vld", {63'd0, out_valid}, 64'd0);

    // One-hot sweep: each result is one-hot, correct, and distinct.
    seen = '0;
    for (int i = 0; i < 64; i++) begin
      x = 64'd1 << i;
      put(1'b1, x, 1'b0);
      @(posedge clk);
      #1;
      r = permuted;
      chk("sweep_onehot", 64'($countones(r)), 64'd1);
      chk("sweep_value", r, model_fwd(x));
      chk("sweep_distinct", seen & r, 64'h0);
      seen |= r;
    end
    chk("sweep_cover", seen, 64'hFFFFFFFFFFFFFFFF);

`ifdef P_LAYER_INV_EN
    send_chk("inv_vec0", 64'h0000000000010000, 1'b1, 64'h0000000000000002);
    send_chk("inv_vec1", 64'h0001000100010001, 1'b1, 64'h000000000000000F);
    for (int k = 0; k < 8; k++) begin
      x = {$urandom, $urandom};
      put(1'b1, x, 1'b0);
      @(posedge clk);
      #1;
      r = permuted;
      send_chk("inv_roundtrip", r, 1'b1, x);
    end
`endif

    // Asynchronous reset mid-stream with a word in flight.
    put(1'b1, 64'hDEADBEEFCAFEF00D, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_permuted", permuted, 64'h0);
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #2;
    x = {$urandom, $urandom};
    original = x;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_word", permuted, model_fwd(x));
    chk("post_rst_vld", {63'd0, out_valid}, 64'd1);

    // Random traffic checked every cycle by the compare process.
    for (int k = 0; k < 400; k++) begin
`ifdef P_LAYER_INV_EN
      put(($urandom % 3) != 0, {$urandom, $urandom}, $urandom % 2 == 1);
`else
      put(($urandom % 3) != 0, {$urandom, $urandom}, 1'b0);
`endif
    end
    put(1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
